// File: rtl/irq_ctrl_pkg.sv
// Shared constants, register offsets and FSM state type for the interrupt controller.
package irq_ctrl_pkg;

  localparam int unsigned BUS_W           = 19;
  localparam int unsigned REG_SEL_W       = 3;
  localparam int unsigned IRQ_ID_W        = 4;
  localparam int unsigned CLAIM_VALID_BIT = 18;

  localparam logic [REG_SEL_W-1:0] REG_PENDING = 3'd0;
  localparam logic [REG_SEL_W-1:0] REG_ENABLE  = 3'd1;
  localparam logic [REG_SEL_W-1:0] REG_CLAIM   = 3'd2;
  localparam logic [REG_SEL_W-1:0] REG_STATUS  = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Peripheral bus bundle: single-cycle strobe, 19-bit address/data, combinational read data.
interface irq_ctrl_if;
  import irq_ctrl_pkg::*;

  logic             bus_valid;
  logic             bus_write;
  logic [BUS_W-1:0] bus_addr;
  logic [BUS_W-1:0] bus_wdata;
  logic [BUS_W-1:0] bus_rdata;

  modport master (
    output bus_valid, bus_write, bus_addr, bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_valid, bus_write, bus_addr, bus_wdata,
    output bus_rdata
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index of the active vector wins.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 8
) (
  input  logic [N_SRC-1:0]    i_act,
  output logic                o_any,
  output logic [IRQ_ID_W-1:0] o_id
);

  // Scan high to low so the lowest set index is the last assignment.
  always_comb begin
    o_any = 1'b0;
    o_id  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_act[i]) begin
        o_any = 1'b1;
        o_id  = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: sticky pending bits, enables, fixed priority, claim/complete FSM.
// Optional IRQ_CTRL_EDGE_DETECT_EN makes sources pend only on a 0->1 transition.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  irq_ctrl_if.slave        bus,
  input  logic [N_SRC-1:0] irq_src,
  output logic             cpu_irq
);

  logic [N_SRC-1:0]     r_pending;
  logic [N_SRC-1:0]     r_enable;
  logic [IRQ_ID_W-1:0]  r_cur_id;
  logic                 r_err;
  logic                 r_cpu_irq;
  state_e               r_state;
  state_e               w_state_nxt;

  logic [N_SRC-1:0]     w_act;
  logic [N_SRC-1:0]     w_evt;
  logic [N_SRC-1:0]     w_w1c;
  logic [N_SRC-1:0]     w_claim_clr;
  logic                 w_any;
  logic [IRQ_ID_W-1:0]  w_win_id;
  logic                 w_rd;
  logic                 w_wr;
  logic [REG_SEL_W-1:0] w_reg;
  logic                 w_claim_rd;
  logic                 w_claim_wr;
  logic                 w_id_match;
  logic                 w_claim_take;
  logic                 w_complete;
  logic                 w_err_set;
  logic                 w_in_service;
  logic                 w_unused;

  assign w_rd       = bus.bus_valid & ~bus.bus_write;
  assign w_wr       = bus.bus_valid &  bus.bus_write;
  assign w_reg      = bus.bus_addr[4:2];
  assign w_claim_rd = w_rd & (w_reg == REG_CLAIM);
  assign w_claim_wr = w_wr & (w_reg == REG_CLAIM);
  assign w_id_match = (bus.bus_wdata[IRQ_ID_W-1:0] == r_cur_id);
  assign w_unused   = ^{bus.bus_addr, bus.bus_wdata};

`ifdef IRQ_CTRL_EDGE_DETECT_EN
  logic [N_SRC-1:0] r_src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_src_q <= '0;
    else        r_src_q <= irq_src;
  end

  assign w_evt = irq_src & ~r_src_q;
`else
  assign w_evt = irq_src;
`endif

  assign w_act = r_pending & r_enable;

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .i_act (w_act),
    .o_any (w_any),
    .o_id  (w_win_id)
  );

  // FSM state register; cpu_irq is registered off the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cpu_irq <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cpu_irq <= (w_state_nxt == ST_ASSERT);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_any) w_state_nxt = ST_ASSERT;
      ST_ASSERT: begin
        if (w_claim_rd && w_any) w_state_nxt = ST_SERVICE;
        else if (!w_any)         w_state_nxt = ST_IDLE;
      end
      ST_SERVICE: if (w_claim_wr && w_id_match) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_claim_take = 1'b0;
    w_complete   = 1'b0;
    w_err_set    = 1'b0;
    w_in_service = 1'b0;
    case (r_state)
      ST_ASSERT: begin
        w_claim_take = w_claim_rd & w_any;
        w_err_set    = w_claim_wr;
      end
      ST_SERVICE: begin
        w_in_service = 1'b1;
        w_complete   = w_claim_wr &  w_id_match;
        w_err_set    = w_claim_wr & ~w_id_match;
      end
      default:    w_err_set = w_claim_wr;
    endcase
  end

  assign w_w1c       = (w_wr && (w_reg == REG_PENDING)) ? bus.bus_wdata[N_SRC-1:0] : '0;
  assign w_claim_clr = w_claim_take ? (N_SRC'(1) << w_win_id) : '0;

  // New source events override a same-cycle W1C or claim clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_enable  <= '0;
      r_cur_id  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~(w_w1c | w_claim_clr)) | w_evt;
      if (w_wr && (w_reg == REG_ENABLE)) r_enable <= bus.bus_wdata[N_SRC-1:0];
      if (w_claim_take)                  r_cur_id <= w_win_id;
      if (w_err_set)                                             r_err <= 1'b1;
      else if (w_wr && (w_reg == REG_STATUS) && bus.bus_wdata[1]) r_err <= 1'b0;
    end
  end

  always_comb begin
    bus.bus_rdata = '0;
    if (w_rd) begin
      case (w_reg)
        REG_PENDING: bus.bus_rdata = BUS_W'(r_pending);
        REG_ENABLE:  bus.bus_rdata = BUS_W'(r_enable);
        REG_CLAIM:
          if (w_claim_take) bus.bus_rdata = (BUS_W'(1) << CLAIM_VALID_BIT) | BUS_W'(w_win_id);
        REG_STATUS:  bus.bus_rdata = BUS_W'({r_err, w_in_service});
        default:     bus.bus_rdata = '0;
      endcase
    end
  end

  assign cpu_irq = r_cpu_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl; honours IRQ_CTRL_EDGE_DETECT_EN for the held-source case.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int unsigned N_SRC = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_SRC-1:0] irq_src;
  logic             cpu_irq;
  int               n_chk  = 0;
  int               n_pass = 0;

  irq_ctrl_if bus_if ();

  irq_ctrl #(.N_SRC(N_SRC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .irq_src (irq_src),
    .cpu_irq (cpu_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic bus_idle();
    bus_if.bus_valid = 1'b0;
    bus_if.bus_write = 1'b0;
    bus_if.bus_addr  = '0;
    bus_if.bus_wdata = '0;
  endtask

  // Called at a negedge; the access spans exactly one rising edge.
  task automatic bus_wr(input logic [2:0] a, input logic [18:0] d);
    bus_if.bus_valid = 1'b1;
    bus_if.bus_write = 1'b1;
    bus_if.bus_addr  = {14'h2A5, a, 2'b00};
    bus_if.bus_wdata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [18:0] exp);
    logic [18:0] d;
    bus_if.bus_valid = 1'b1;
    bus_if.bus_write = 1'b0;
    bus_if.bus_addr  = {14'h155, a, 2'b00};
    bus_if.bus_wdata = '0;
    #1 d = bus_if.bus_rdata;
    check(tag, 32'(d), 32'(exp));
    @(negedge clk);
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    irq_src = '0;
    bus_idle();
    #12 check("rst_cpu_irq", 32'(cpu_irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset values of every register slot
    for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_reg%0d", a), 3'(a), 19'h0);
    #1 check("rdata_idle", 32'(bus_if.bus_rdata), 32'd0);

    // single source, claim and complete
    bus_wr(REG_ENABLE, 19'h01);
    irq_src = 8'h01;
    @(negedge clk);
    irq_src = '0;
    check("lat_1cyc", 32'(cpu_irq), 32'd0);
    @(negedge clk);
    check("lat_2cyc", 32'(cpu_irq), 32'd1);
    rd_chk("pend_s0", REG_PENDING, 19'h01);
    rd_chk("claim_s0", REG_CLAIM, 19'h40000);
    check("irq_drop", 32'(cpu_irq), 32'd0);
    rd_chk("stat_svc", REG_STATUS, 19'h1);
    rd_chk("pend_clr", REG_PENDING, 19'h0);
    rd_chk("claim_svc", REG_CLAIM, 19'h0);
    bus_wr(REG_CLAIM, 19'h0);
    rd_chk("stat_done", REG_STATUS, 19'h0);
    check("irq_done", 32'(cpu_irq), 32'd0);

    // priority between sources 5 and 2, wrong-id complete
    bus_wr(REG_ENABLE, 19'hFF);
    irq_src = 8'h24;
    @(negedge clk);
    irq_src = '0;
    @(negedge clk);
    check("irq_pri", 32'(cpu_irq), 32'd1);
    rd_chk("claim_id2", REG_CLAIM, 19'h40002);
    rd_chk("pend_left5", REG_PENDING, 19'h20);
    bus_wr(REG_CLAIM, 19'h3);
    rd_chk("stat_err", REG_STATUS, 19'h3);
    check("irq_svc_hold", 32'(cpu_irq), 32'd0);
    bus_wr(REG_STATUS, 19'h2);
    rd_chk("stat_errclr", REG_STATUS, 19'h1);
    bus_wr(REG_CLAIM, 19'h2);
    check("irq_cmpl_e1", 32'(cpu_irq), 32'd0);
    @(negedge clk);
    check("irq_cmpl_e2", 32'(cpu_irq), 32'd1);
    rd_chk("claim_id5", REG_CLAIM, 19'h40005);
    bus_wr(REG_CLAIM, 19'h5);
    rd_chk("claim_idle", REG_CLAIM, 19'h0);
    bus_wr(REG_CLAIM, 19'h5);
    rd_chk("stat_idle_err", REG_STATUS, 19'h2);
    bus_wr(REG_STATUS, 19'h2);
    rd_chk("stat_clr2", REG_STATUS, 19'h0);

    // source event beats a same-cycle W1C
    bus_wr(REG_ENABLE, 19'h00);
    irq_src = 8'h02;
    bus_wr(REG_PENDING, 19'h02);
    irq_src = '0;
    rd_chk("w1c_race", REG_PENDING, 19'h02);
    bus_wr(REG_PENDING, 19'h02);
    rd_chk("w1c_plain", REG_PENDING, 19'h00);

    // disabled source latches, enabling later raises the line
    irq_src = 8'h10;
    @(negedge clk);
    irq_src = '0;
    @(negedge clk);
    check("irq_disabled", 32'(cpu_irq), 32'd0);
    rd_chk("pend_disabled", REG_PENDING, 19'h10);
    bus_wr(REG_ENABLE, 19'h10);
    check("en_lat1", 32'(cpu_irq), 32'd0);
    @(negedge clk);
    check("en_lat2", 32'(cpu_irq), 32'd1);
    bus_wr(REG_PENDING, 19'h10);
    @(negedge clk);
    check("act_drop", 32'(cpu_irq), 32'd0);

    // held-high source
    bus_wr(REG_ENABLE, 19'h08);
    irq_src = 8'h08;
    @(negedge clk);
    @(negedge clk);
    check("hold_irq", 32'(cpu_irq), 32'd1);
    rd_chk("hold_claim", REG_CLAIM, 19'h40003);
    bus_wr(REG_CLAIM, 19'h3);
    @(negedge clk);
`ifdef IRQ_CTRL_EDGE_DETECT_EN
    check("hold_no_repeat", 32'(cpu_irq), 32'd0);
    repeat (14) @(negedge clk);
    check("hold_still_quiet", 32'(cpu_irq), 32'd0);
    irq_src = '0;
    rd_chk("hold_pend", REG_PENDING, 19'h0);
    rd_chk("hold_claim2", REG_CLAIM, 19'h0);
`else
    check("hold_repeat", 32'(cpu_irq), 32'd1);
    repeat (14) @(negedge clk);
    check("hold_still_high", 32'(cpu_irq), 32'd1);
    irq_src = '0;
    rd_chk("hold_claim2", REG_CLAIM, 19'h40003);
    bus_wr(REG_CLAIM, 19'h3);
    rd_chk("hold_pend", REG_PENDING, 19'h0);
`endif

    // reset during service discards everything
    bus_wr(REG_ENABLE, 19'h01);
    irq_src = 8'h01;
    @(negedge clk);
    irq_src = '0;
    @(negedge clk);
    rd_chk("pre_rst_claim", REG_CLAIM, 19'h40000);
    bus_wr(REG_CLAIM, 19'h7);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_irq", 32'(cpu_irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("rst_mid_stat", REG_STATUS, 19'h0);
    rd_chk("rst_mid_en", REG_ENABLE, 19'h0);
    rd_chk("rst_mid_claim", REG_CLAIM, 19'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
